// File: rtl/count_ctrl_pkg.sv
// Shared encodings for the counter enable generator: Mode/FSM values and the
// levels the input synchronizers take while Clear is high.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_STEP = 2'b10
    } mode_e;

    localparam logic RUN_SW_RESET_LEVEL   = 1'b0;
    localparam logic STEP_KEY_RESET_LEVEL = 1'b1;

endpackage

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: 2-FF synchronizer, optional debounce filter and a
// one-cycle falling-edge strobe. The filter exists only when DEBOUNCE_EN is defined.
module key_conditioner
    import count_ctrl_pkg::*;
#(
    parameter logic RESET_LEVEL = STEP_KEY_RESET_LEVEL
`ifdef DEBOUNCE_EN
    ,
    parameter int          DB_W      = 20,
    parameter int unsigned DB_CYCLES = 500_000
`endif
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic key_i,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            meta_q <= RESET_LEVEL;
            sync_q <= RESET_LEVEL;
        end else begin
            meta_q <= key_i;
            sync_q <= meta_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] dbCnt_q, dbCnt_d;
    logic            dbLevel_q, dbLevel_d;

    // Any sample matching the current level restarts the stability count.
    always_comb begin
        dbCnt_d   = '0;
        dbLevel_d = dbLevel_q;
        if (sync_q != dbLevel_q) begin
            if (dbCnt_q == DbLast) begin
                dbLevel_d = sync_q;
            end else begin
                dbCnt_d = dbCnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            dbCnt_q   <= '0;
            dbLevel_q <= RESET_LEVEL;
        end else begin
            dbCnt_q   <= dbCnt_d;
            dbLevel_q <= dbLevel_d;
        end
    end

    assign level = dbLevel_q;
`else
    assign level = sync_q;
`endif

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            prev_q <= RESET_LEVEL;
        end else begin
            prev_q <= level;
        end
    end

    assign fall_o = prev_q & ~level;

endmodule

// File: rtl/count_enable_gen.sv
// Enable generator for the 16-bit T-FF counter: periodic pulses in RUN, one pulse per
// step press otherwise. Define DEBOUNCE_EN to debounce the step pushbutton.
module count_enable_gen
    import count_ctrl_pkg::*;
#(
    parameter int          DIV_W   = 26,
    parameter int unsigned DIV_MAX = 49_999_999
`ifdef DEBOUNCE_EN
    ,
    parameter int          DB_W      = 20,
    parameter int unsigned DB_CYCLES = 500_000
`endif
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       RunSw,
    input  logic       StepKey,
    input  logic [1:0] RateSel,
    output logic       Enable,
    output logic [1:0] Mode
);

    localparam logic [DIV_W-1:0] DivMax = DIV_W'(DIV_MAX);

    mode_e            state_q, state_d;
    logic             runMeta_q, runSync_q;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] terminal;
    logic             tick;
    logic             press;
    logic             enable_q, enable_d;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            runMeta_q <= RUN_SW_RESET_LEVEL;
            runSync_q <= RUN_SW_RESET_LEVEL;
        end else begin
            runMeta_q <= RunSw;
            runSync_q <= runMeta_q;
        end
    end

    key_conditioner #(
        .RESET_LEVEL (STEP_KEY_RESET_LEVEL)
`ifdef DEBOUNCE_EN
        ,
        .DB_W        (DB_W),
        .DB_CYCLES   (DB_CYCLES)
`endif
    ) uStepKey (
        .clk_i   (Clock),
        .clear_i (Clear),
        .key_i   (StepKey),
        .fall_o  (press)
    );

    // >= rather than == so a rate change that drops below the count wraps at once.
    assign terminal = DivMax >> {RateSel, 1'b0};
    assign tick     = (state_q == MODE_RUN) && (cnt_q >= terminal);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        enable_d = tick || (state_q == MODE_STEP);
        unique case (state_q)
            MODE_IDLE: begin
                if (runSync_q) begin
                    state_d = MODE_RUN;
                end else if (press) begin
                    state_d = MODE_STEP;
                end
            end
            MODE_RUN: begin
                if (!runSync_q) begin
                    state_d = MODE_IDLE;
                end
            end
            MODE_STEP: state_d = MODE_IDLE;
            default:   state_d = MODE_IDLE;
        endcase
        if ((state_q == MODE_RUN) && (state_d == MODE_RUN) && !tick) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q  <= MODE_IDLE;
            cnt_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
        end
    end

    assign Enable = enable_q;
    assign Mode   = state_q;

endmodule
